csr_bank: RTL

CSR_BANK -- requirements
Module: csr_bank

---
 rtl/csr_bank.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/csr_bank.sv
// Register bank with read/write config regs, read-only status regs and an asynchronous write strobe.
// Optional event/mask interrupt registers are enabled by defining CSR_BANK_IRQ_EN.
module csr_bank #(
    parameter int unsigned ADDR_WIDTH     = 7,
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned NUM_CONFIG_REG = 12,
    parameter int unsigned NUM_STATUS_REG = 4,
    parameter int unsigned SYNC_STAGES    = 3,
    parameter logic [NUM_CONFIG_REG*DATA_WIDTH-1:0] CONFIG_RESET = '0,
    parameter logic [NUM_CONFIG_REG*DATA_WIDTH-1:0] CONFIG_WMASK = '1
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [ADDR_WIDTH-1:0]                addr_i,
    input  logic [DATA_WIDTH-1:0]                write_data_i,
    input  logic                                 write_en_i,
    input  logic                                 read_en_i,
    output logic [DATA_WIDTH-1:0]                read_data_o,
    output logic                                 read_valid_o,
    output logic                                 write_ack_o,
    output logic [DATA_WIDTH*NUM_CONFIG_REG-1:0] config_bus_o,
    input  logic [DATA_WIDTH*NUM_STATUS_REG-1:0] status_bus_i,
    input  logic [DATA_WIDTH-1:0]                event_i,
    output logic                                 irq_o
);

    if (SYNC_STAGES < 2) begin : gen_bad_sync
        $error("SYNC_STAGES must be at least 2");
    end

    localparam int unsigned EvtAddr  = NUM_CONFIG_REG + NUM_STATUS_REG;
    localparam int unsigned MaskAddr = EvtAddr + 1;
    localparam logic [NUM_CONFIG_REG-1:0][DATA_WIDTH-1:0] WMask = CONFIG_WMASK;

    logic [31:0] addr_w;
    assign addr_w = 32'(addr_i);

    // Write strobe synchronizer; vld_q marks stages holding real samples taken after reset,
    // and arm_q blocks pulses until a genuine low has been seen (no pulse for a write held
    // across reset).
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] vld_q;
    logic                   edge_q;
    logic                   arm_q;
    logic                   wr_pulse;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
            vld_q  <= '0;
            edge_q <= 1'b0;
            arm_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], write_en_i};
            vld_q  <= {vld_q[SYNC_STAGES-2:0], 1'b1};
            edge_q <= sync_q[SYNC_STAGES-1];
            if (vld_q[SYNC_STAGES-1] && !sync_q[SYNC_STAGES-1]) begin
                arm_q <= 1'b1;
            end
        end
    end

    assign wr_pulse = arm_q & sync_q[SYNC_STAGES-1] & ~edge_q;

    logic [NUM_CONFIG_REG-1:0][DATA_WIDTH-1:0] cfg_q, cfg_d;
    logic                                      ack_q;

    always_comb begin
        cfg_d = cfg_q;
        for (int unsigned i = 0; i < NUM_CONFIG_REG; i++) begin
            if (wr_pulse && addr_w == i) begin
                cfg_d[i] = (cfg_q[i] & ~WMask[i]) | (write_data_i & WMask[i]);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cfg_q <= CONFIG_RESET;
            ack_q <= 1'b0;
        end else begin
            cfg_q <= cfg_d;
            ack_q <= wr_pulse;
        end
    end

    assign config_bus_o = cfg_q;
    assign write_ack_o  = ack_q;

`ifdef CSR_BANK_IRQ_EN
    logic [DATA_WIDTH-1:0] evt_q, evt_d, mask_q, mask_d;
    logic                  irq_q;

    // Event set is applied after the W1C clear so a same-cycle event wins.
    always_comb begin
        evt_d  = evt_q;
        mask_d = mask_q;
        if (wr_pulse && addr_w == EvtAddr) begin
            evt_d = evt_q & ~write_data_i;
        end
        if (wr_pulse && addr_w == MaskAddr) begin
            mask_d = write_data_i;
        end
        evt_d = evt_d | event_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            evt_q  <= '0;
            mask_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            evt_q  <= evt_d;
            mask_q <= mask_d;
            irq_q  <= |(evt_q & mask_q);
        end
    end

    assign irq_o = irq_q;
`else
    logic unused_event;
    assign unused_event = ^event_i;
    assign irq_o        = 1'b0;
`endif

    logic [DATA_WIDTH-1:0] rd_mux;

    always_comb begin
        rd_mux = '1;
        for (int unsigned i = 0; i < NUM_CONFIG_REG; i++) begin
            if (addr_w == i) begin
                rd_mux = cfg_q[i];
            end
        end
        for (int unsigned i = 0; i < NUM_STATUS_REG; i++) begin
            if (addr_w == NUM_CONFIG_REG + i) begin
                rd_mux = status_bus_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
`ifdef CSR_BANK_IRQ_EN
        if (addr_w == EvtAddr) begin
            rd_mux = evt_q;
        end
        if (addr_w == MaskAddr) begin
            rd_mux = mask_q;
        end
`endif
    end

    logic                  rd_vld1_q;
    logic [DATA_WIDTH-1:0] rd_data1_q;
    logic                  read_valid_q;
    logic [DATA_WIDTH-1:0] read_data_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_vld1_q    <= 1'b0;
            rd_data1_q   <= '0;
            read_valid_q <= 1'b0;
            read_data_q  <= '0;
        end else begin
            rd_vld1_q    <= read_en_i;
            if (read_en_i) begin
                rd_data1_q <= rd_mux;
            end
            read_valid_q <= rd_vld1_q;
            if (rd_vld1_q) begin
                read_data_q <= rd_data1_q;
            end
        end
    end

    assign read_data_o  = read_data_q;
    assign read_valid_o = read_valid_q;

endmodule
